vc_qspi_ram_responder: RTL
==========================

// Module: vc_qspi_ram_responder
// PURPOSE
//  Quad-SPI RAM responder: the memory-side end of the serial bus the vc CPU drives on its uio pins.
//  Decodes command/address nibbles and serves reads and writes from an internal byte array.
//  Used in the FPGA/sim harness beside the CPU top.
//  Runs in the responder's own clk domain and oversamples the bus (clk >= 4x sclk).
// PARAMETERS
//  PA         24   address bits on the wire (PA/4 address nibbles, MSN first)
//  MEM_DEPTH  256  bytes of backing store, power of 2; uses addr[$clog2(MEM_DEPTH)-1:0]
//  DUMMY      4    sclk cycles between last address nibble and first read nibble
// PORTS
//  clk        in   1  responder clock
//  reset      in   1  asynchronous, active-high reset
//  spi_cs_n   in   1  chip select, active low, from CPU
//  spi_sclk   in   1  serial clock from CPU, idle low
//  spi_d_in   in   4  quad data in (CPU -> responder)
//  spi_d_out  out  4  quad data out (responder -> CPU)
//  spi_d_oe   out  4  output enable, all bits equal (4'hF or 4'h0)
// BEHAVIOUR
//  - Reset: spi_d_out=0, spi_d_oe=0, state IDLE, counters 0; memory contents not reset.
//  - cs_n, sclk, d_in each pass a 2-flop synchronizer (same depth, so data stays aligned with sclk).
//    Rise/fall edges are detected on synchronized sclk; no sclk edge is acted on while synced cs_n=1.
//  - Rising sclk edge: sample d_in. Falling sclk edge: update d_out.
//  - Byte nibble order is high nibble first. Command = 2 nibbles. Address = PA/4 nibbles.
//  - States and transitions:
//    IDLE: cs_n falling -> CMD (nibble count cleared).
//    CMD: after 2 nibbles: RD_CMD(8'hEB) -> ADDR(rd); WR_CMD(8'h38) -> ADDR(wr); any other -> IGNORE.
//    ADDR: shift in PA/4 nibbles -> DUMMY (rd) or WDATA (wr).
//    DUMMY: count DUMMY rising edges -> RDATA.
//      On the falling edge of the last dummy cycle: drive high nibble of mem[addr], set oe=F.
//    RDATA: each falling edge drives the next nibble; after the low nibble, addr+1 and the
//      high nibble of the new byte follows. CPU samples on rising edges.
//    WDATA: two rising-edge nibbles form a byte; write mem[addr] on the 2nd nibble, then addr+1.
//    IGNORE: oe=0 and no memory access until cs_n rises.
//  - Address increment wraps modulo MEM_DEPTH; upper wire-address bits are ignored (aliasing).
//  - cs_n rise (synced) in any state: -> IDLE next clk, oe=0, d_out=0; a half-received write
//    byte is discarded. Worst case oe drop <= 3 clk after pin cs_n rises.
//  - A cs_n rise and an sclk edge seen in the same clk: the cs_n rise wins and the edge is ignored.
//  - Read-after-write to the same address in a later transaction returns the written data.
//  - Reset asserted mid-transfer: immediate IDLE and oe=0; memory keeps already-written bytes.
// STRUCTURE
//  - Package vc_qspi_pkg: RD_CMD/WR_CMD constants and the state enum
//    (IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE).
//  - Sub-module vc_sync_edge: 2-flop sync + rise/fall pulse outputs, instanced for sclk and cs_n.
//    d_in uses a plain 2-flop sync.
//  - Memory is an inferred reg array with one write port and one async read port.
// TESTING
//  1. Reset asserted, bus idle -> spi_d_oe=0, spi_d_out=0; no state change on stray sclk while cs_n=1.
//  2. Write: cs_n=0, cmd 38, addr 000010, data A5 3C, cs_n=1 -> mem[10]=A5, mem[11]=3C, oe never set.
//  3. Read: cmd EB, addr 000010, 4 dummy cycles -> nibbles A,5,3,C on successive rising edges; oe=F
//     only from the last dummy falling edge to cs_n rise (+<=3 clk).
//  4. Wrap: write addr 0000FF (MEM_DEPTH=256) data 11 22 -> mem[FF]=11, mem[00]=22; read back
//     from FF returns 1,1,2,2.
//  5. Abort: cs_n rises after 3 address nibbles -> IDLE, oe=0, memory unchanged.
//     The following full read of 000010 returns A5.
//  6. Unknown cmd 9F then 8 nibbles of data -> oe stays 0, memory unchanged, next transaction decodes normally.

Source files
------------

// File: rtl/vc_qspi_pkg.sv
// vc_qspi_pkg: command codes and FSM states shared by the quad-SPI RAM responder.
package vc_qspi_pkg;
    localparam logic [7:0] RD_CMD = 8'hEB;
    localparam logic [7:0] WR_CMD = 8'h38;
    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
    } state_e;
endpackage

// File: rtl/vc_sync_edge.sv
// vc_sync_edge: 2-flop synchronizer with rise/fall pulses taken from the synchronized level.
module vc_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    output logic rise,
    output logic fall
);
    logic [2:0] sh_q, sh_d;
    always_comb begin
        sh_d = {sh_q[1:0], a};
        rise = sh_q[1] & ~sh_q[2];
        fall = ~sh_q[1] & sh_q[2];
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) sh_q <= {3{RST_VAL}};
        else       sh_q <= sh_d;
endmodule

// File: rtl/vc_qspi_ram_responder.sv
// vc_qspi_ram_responder: quad-SPI RAM responder serving reads/writes from an internal byte array.
// Oversamples the bus in its own clk domain; sclk, cs_n and data share one sync depth.
module vc_qspi_ram_responder
    import vc_qspi_pkg::*;
#(
    parameter int PA        = 24,
    parameter int MEM_DEPTH = 256,
    parameter int DUMMY     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic [3:0] spi_d_in,
    output logic [3:0] spi_d_out,
    output logic [3:0] spi_d_oe
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int NA = PA / 4;

    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [3:0] din1_q, din_s;
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] cmd_q, cmd_d, hi_q, hi_d, dout_q, dout_d;
    logic       rd_q, rd_d, ph_q, ph_d, oe_q, oe_d, mem_we;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0] mem_wdata, rd_byte;
    logic [7:0] mem [MEM_DEPTH];

    vc_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .a(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
    );
    vc_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .a(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    assign rd_byte   = mem[addr_q];
    assign spi_d_out = dout_q;
    assign spi_d_oe  = {4{oe_q}};

    // Outside IDLE cs_n is known low, so edges there are always inside a transaction.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        hi_d      = hi_q;
        ph_d      = ph_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        mem_we    = 1'b0;
        mem_wdata = {hi_q, din_s};
        if (cs_rise) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            dout_d  = 4'h0;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = 8'd0;
                end
                ST_CMD: if (sclk_rise) begin
                    cmd_d = din_s;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        cnt_d   = 8'd0;
                        rd_d    = ({cmd_q, din_s} == RD_CMD);
                        state_d = ({cmd_q, din_s} == RD_CMD || {cmd_q, din_s} == WR_CMD)
                                  ? ST_ADDR : ST_IGNORE;
                    end
                end
                ST_ADDR: if (sclk_rise) begin
                    addr_d = AW'({addr_q, din_s});
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'(NA - 1)) begin
                        cnt_d   = 8'd0;
                        ph_d    = 1'b0;
                        state_d = rd_q ? ST_DUMMY : ST_WDATA;
                    end
                end
                ST_DUMMY: if (sclk_rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(DUMMY - 1)) begin
                        cnt_d   = 8'd0;
                        state_d = ST_RDATA;
                    end
                end
                ST_RDATA: if (sclk_fall) begin
                    oe_d   = 1'b1;
                    dout_d = ph_q ? rd_byte[3:0] : rd_byte[7:4];
                    ph_d   = ~ph_q;
                    addr_d = ph_q ? addr_q + AW'(1) : addr_q;
                end
                ST_WDATA: if (sclk_rise) begin
                    ph_d   = ~ph_q;
                    hi_d   = ph_q ? hi_q : din_s;
                    mem_we = ph_q;
                    addr_d = ph_q ? addr_q + AW'(1) : addr_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            din1_q  <= 4'h0;
            din_s   <= 4'h0;
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            cmd_q   <= 4'h0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            hi_q    <= 4'h0;
            ph_q    <= 1'b0;
            dout_q  <= 4'h0;
            oe_q    <= 1'b0;
        end else begin
            din1_q  <= spi_d_in;
            din_s   <= din1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            hi_q    <= hi_d;
            ph_q    <= ph_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
        end

    always_ff @(posedge clk)
        if (mem_we) mem[addr_q] <= mem_wdata;
endmodule
